// File: rtl/mitchell_log_multiplier.sv
// Mitchell logarithmic 8x8 unsigned approximate multiplier, 2-stage pipeline.
// Ports: clk, rst (sync, active-high), in_valid, A, B -> out_valid, result,
//   debug taps (zero flags, leading, fraction, log_A/B, carry, log_result).
// Macro LOG_MULT_TAPS_EN: when defined the taps are driven, else tied to 0.
module mitchell_log_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  output logic        zero_flag_A,
  output logic        zero_flag_B,
  output logic [2:0]  leading_A,
  output logic [2:0]  leading_B,
  output logic [6:0]  fraction_A,
  output logic [6:0]  fraction_B,
  output logic [9:0]  log_A,
  output logic [9:0]  log_B,
  output logic        fraction_sum_carry,
  output logic [10:0] log_result,
  output logic [15:0] result
);

  function automatic logic [2:0] lead_one(input logic [7:0] v);
    lead_one = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) lead_one = i[2:0];
  endfunction

  // stage 1 state
  logic       v1_q, v1_d;
  logic       za_q, za_d, zb_q, zb_d;
  logic [2:0] ka_q, ka_d, kb_q, kb_d;
  logic [6:0] xa_q, xa_d, xb_q, xb_d;

  // stage 2 state
  logic        ov_q, ov_d;
  logic [15:0] res_q, res_d;

  logic [2:0] ka_n, kb_n;
  logic [7:0] sha, shb;

  always_comb begin
    ka_n = lead_one(A);
    kb_n = lead_one(B);
    // normalise so the leading one lands in bit 7; bits below are x
    sha  = A << (3'd7 - ka_n);
    shb  = B << (3'd7 - kb_n);
    v1_d = in_valid;
    za_d = za_q;
    zb_d = zb_q;
    ka_d = ka_q;
    kb_d = kb_q;
    xa_d = xa_q;
    xb_d = xb_q;
    if (in_valid) begin
      za_d = (A == 8'd0);
      zb_d = (B == 8'd0);
      ka_d = ka_n;
      kb_d = kb_n;
      xa_d = sha[6:0];
      xb_d = shb[6:0];
    end
  end

  logic [7:0]  fsum;
  logic [3:0]  big_k;
  logic [7:0]  mant;
  logic [22:0] wide;
  logic [15:0] prod;

  always_comb begin
    fsum  = {1'b0, xa_q} + {1'b0, xb_q};
    big_k = {1'b0, ka_q} + {1'b0, kb_q} + {3'b0, fsum[7]};
    // antilog: (1.F) * 2^K, then drop the 7 fraction bits
    mant  = {1'b1, fsum[6:0]};
    wide  = {15'b0, mant} << big_k;
    prod  = 16'(wide >> 7);
    if (za_q || zb_q) prod = 16'd0;
    ov_d  = v1_q;
    res_d = v1_q ? prod : res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      za_q  <= 1'b0;
      zb_q  <= 1'b0;
      ka_q  <= 3'd0;
      kb_q  <= 3'd0;
      xa_q  <= 7'd0;
      xb_q  <= 7'd0;
      ov_q  <= 1'b0;
      res_q <= 16'd0;
    end else begin
      v1_q  <= v1_d;
      za_q  <= za_d;
      zb_q  <= zb_d;
      ka_q  <= ka_d;
      kb_q  <= kb_d;
      xa_q  <= xa_d;
      xb_q  <= xb_d;
      ov_q  <= ov_d;
      res_q <= res_d;
    end
  end

  assign out_valid = ov_q;
  assign result    = res_q;

`ifdef LOG_MULT_TAPS_EN
  logic        tza_q, tza_d, tzb_q, tzb_d;
  logic [2:0]  tka_q, tka_d, tkb_q, tkb_d;
  logic [6:0]  txa_q, txa_d, txb_q, txb_d;
  logic        tc_q, tc_d;
  logic [10:0] tlr_q, tlr_d;
  logic [9:0]  la, lb;

  always_comb begin
    la    = {3'b0, ka_q, xa_q};
    lb    = {3'b0, kb_q, xb_q};
    tza_d = tza_q;
    tzb_d = tzb_q;
    tka_d = tka_q;
    tkb_d = tkb_q;
    txa_d = txa_q;
    txb_d = txb_q;
    tc_d  = tc_q;
    tlr_d = tlr_q;
    if (v1_q) begin
      tza_d = za_q;
      tzb_d = zb_q;
      tka_d = ka_q;
      tkb_d = kb_q;
      txa_d = xa_q;
      txb_d = xb_q;
      tc_d  = fsum[7];
      tlr_d = {1'b0, la} + {1'b0, lb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tza_q <= 1'b0;
      tzb_q <= 1'b0;
      tka_q <= 3'd0;
      tkb_q <= 3'd0;
      txa_q <= 7'd0;
      txb_q <= 7'd0;
      tc_q  <= 1'b0;
      tlr_q <= 11'd0;
    end else begin
      tza_q <= tza_d;
      tzb_q <= tzb_d;
      tka_q <= tka_d;
      tkb_q <= tkb_d;
      txa_q <= txa_d;
      txb_q <= txb_d;
      tc_q  <= tc_d;
      tlr_q <= tlr_d;
    end
  end

  assign zero_flag_A        = tza_q;
  assign zero_flag_B        = tzb_q;
  assign leading_A          = tka_q;
  assign leading_B          = tkb_q;
  assign fraction_A         = txa_q;
  assign fraction_B         = txb_q;
  assign log_A              = {3'b0, tka_q, txa_q};
  assign log_B              = {3'b0, tkb_q, txb_q};
  assign fraction_sum_carry = tc_q;
  assign log_result         = tlr_q;
`else
  assign zero_flag_A        = 1'b0;
  assign zero_flag_B        = 1'b0;
  assign leading_A          = 3'd0;
  assign leading_B          = 3'd0;
  assign fraction_A         = 7'd0;
  assign fraction_B         = 7'd0;
  assign log_A              = 10'd0;
  assign log_B              = 10'd0;
  assign fraction_sum_carry = 1'b0;
  assign log_result         = 11'd0;
`endif

endmodule

// File: tb/tb_mitchell_log_multiplier.sv
// Scoreboard bench for mitchell_log_multiplier: random and directed operands
// checked against an arithmetic model of Mitchell's approximation.
module tb_mitchell_log_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  A, B;
  logic        out_valid;
  logic        zero_flag_A, zero_flag_B;
  logic [2:0]  leading_A, leading_B;
  logic [6:0]  fraction_A, fraction_B;
  logic [9:0]  log_A, log_B;
  logic        fraction_sum_carry;
  logic [10:0] log_result;
  logic [15:0] result;

  mitchell_log_multiplier dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(out_valid),
    .zero_flag_A(zero_flag_A), .zero_flag_B(zero_flag_B),
    .leading_A(leading_A), .leading_B(leading_B),
    .fraction_A(fraction_A), .fraction_B(fraction_B),
    .log_A(log_A), .log_B(log_B),
    .fraction_sum_carry(fraction_sum_carry),
    .log_result(log_result), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, b, za, zb, ka, kb, xa, xb, la, lb, c, lr, res, cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int lead(int v);
    int k = 0;
    for (int i = 0; i < 8; i++)
      if (v >= (1 << i)) k = i;
    return k;
  endfunction

  function automatic exp_t model(int a, int b, int c);
    exp_t e;
    int s, bigk, f;
    longint r;
    e.a = a; e.b = b; e.cyc = c;
    e.za = (a == 0); e.zb = (b == 0);
    e.ka = lead(a); e.kb = lead(b);
    e.xa = (a * (1 << (7 - e.ka))) % 128;
    e.xb = (b * (1 << (7 - e.kb))) % 128;
    e.la = e.ka * 128 + e.xa;
    e.lb = e.kb * 128 + e.xb;
    e.lr = e.la + e.lb;
    s = e.xa + e.xb;
    e.c = (s >= 128);
    bigk = e.ka + e.kb + e.c;
    f = s % 128;
    r = (longint'(128 + f) * (longint'(1) << bigk)) / 128;
    e.res = (e.za || e.zb) ? 0 : int'(r);
    return e;
  endfunction

  task automatic drive(int a, int b);
    @(negedge clk);
    A = a[7:0];
    B = b[7:0];
    in_valid = 1'b1;
    q.push_back(model(a, b, cyc + 2));
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_ov"}, 32'(out_valid), 0);
    chk({nm, "_res"}, 32'(result), 0);
    chk({nm, "_taps"}, 32'({zero_flag_A, zero_flag_B, leading_A, leading_B,
                            fraction_A, fraction_B}), 0);
    chk({nm, "_logs"}, 32'({log_A, log_B, fraction_sum_carry}), 0);
    chk({nm, "_lr"}, 32'(log_result), 0);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a result
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid actual=1 required=0");
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc), 32'(e.cyc));
          chk("result", 32'(result), 32'(e.res));
          chk("no_overshoot", 32'(int'(result) <= e.a * e.b), 1);
`ifdef LOG_MULT_TAPS_EN
          chk("zero_A", 32'(zero_flag_A), 32'(e.za));
          chk("zero_B", 32'(zero_flag_B), 32'(e.zb));
          chk("leading_A", 32'(leading_A), 32'(e.ka));
          chk("leading_B", 32'(leading_B), 32'(e.kb));
          chk("fraction_A", 32'(fraction_A), 32'(e.xa));
          chk("fraction_B", 32'(fraction_B), 32'(e.xb));
          chk("log_A", 32'(log_A), 32'(e.la));
          chk("log_B", 32'(log_B), 32'(e.lb));
          chk("carry", 32'(fraction_sum_carry), 32'(e.c));
          chk("log_result", 32'(log_result), 32'(e.lr));
`else
          chk("taps_tied", 32'({zero_flag_A, zero_flag_B, leading_A,
                                leading_B, fraction_A, fraction_B}), 0);
          chk("logs_tied", 32'({log_A, log_B, fraction_sum_carry}), 0);
          chk("lr_tied", 32'(log_result), 0);
`endif
        end
      end
    end
  end

  initial begin
    int r;
    rst = 1'b1;
    in_valid = 1'b0;
    A = 8'd0;
    B = 8'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // fixed points from the spec
    drive(6, 6);
    idle(3);
    drive(128, 128);
    drive(255, 255);
    drive(0, 77);
    drive(1, 1);
    idle(1);
    drive(3, 5);
    drive(12, 10);
    drive(200, 3);
    idle(4);

    // reset one cycle after an accepted op discards it
    drive(9, 9);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk_zero("midreset");
    rst = 1'b0;
    idle(3);
    drive(7, 9);
    idle(3);

    // randomized traffic with bubbles, zeros and powers of two mixed in
    for (int i = 0; i < 400; i++) begin
      int a, b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      r = $urandom_range(0, 9);
      if (r == 0) a = 0;
      if (r == 1) b = 1 << $urandom_range(0, 7);
      if (r == 2) a = 255;
      if ($urandom_range(0, 3) == 0) idle(1);
      else drive(a, b);
    end
    idle(6);
    chk("drain_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
